// File: rtl/aclk_controller.sv
// -----------------------------------------------------------------------------
// aclk_controller
//   User-interface FSM for the alarm clock. It sits upstream of the time
//   counter and the alarm register. It reads keypad digits and the alarm/time
//   buttons, and it drives the keypad shift register. It issues single-cycle
//   load strobes for current time and alarm time, and it selects the display
//   source.
//
//   Moore machine: every output is decoded from the state register alone.
//
// Configuration macro:
//   ACLK_CTRL_TIMEOUT_EN  - when defined, builds the inactivity counter that
//                           abandons a key entry after TIMEOUT_SEC seconds.
//                           When undefined, key entry waits indefinitely and
//                           one_second is ignored.
//
// Ports:
//   clk            in   system clock, rising edge
//   reset          in   asynchronous, active-high; clears all state
//   one_second     in   1-cycle pulse once per second
//   key[3:0]       in   decoded keypad value, NOKEY when idle
//   alarm_button   in   level, high while held
//   time_button    in   level, high while held
//   load_new_a     out  1-cycle strobe: alarm register loads keypad buffer
//   load_new_c     out  1-cycle strobe: time counter loads keypad buffer
//   show_a         out  display selects alarm time
//   show_new_time  out  display selects keypad buffer
//   shift          out  1-cycle strobe: keypad buffer shifts in key
//   reset_count    out  1-cycle strobe: timegen clears its seconds divider
// -----------------------------------------------------------------------------
module aclk_controller #(
  parameter int         TIMEOUT_SEC = 10,
  parameter logic [3:0] NOKEY       = 4'hA
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       one_second,
  input  logic [3:0] key,
  input  logic       alarm_button,
  input  logic       time_button,
  output logic       load_new_a,
  output logic       load_new_c,
  output logic       show_a,
  output logic       show_new_time,
  output logic       shift,
  output logic       reset_count
);

  localparam logic [2:0] SHOW_TIME        = 3'd0;
  localparam logic [2:0] KEY_STORED       = 3'd1;
  localparam logic [2:0] KEY_WAITED       = 3'd2;
  localparam logic [2:0] KEY_ENTRY        = 3'd3;
  localparam logic [2:0] SHOW_ALARM       = 3'd4;
  localparam logic [2:0] SET_ALARM_TIME   = 3'd5;
  localparam logic [2:0] SET_CURRENT_TIME = 3'd6;

  logic [2:0] state_q, state_d;
  logic       key_pressed;
  logic       timeout;

  // Codes B-F are not NOKEY, so they count as digits.
  assign key_pressed = (key != NOKEY);

`ifdef ACLK_CTRL_TIMEOUT_EN
  localparam int             CNT_W    = $clog2(TIMEOUT_SEC + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_SEC);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_SEC - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             waiting;

  // The counter is held at zero outside the two waiting states. Each
  // KEY_STORED visit therefore restarts the inactivity window.
  always_comb begin
    waiting = (state_q == KEY_WAITED) || (state_q == KEY_ENTRY);
    cnt_d   = '0;
    if (waiting) begin
      cnt_d = cnt_q;
      if (one_second && (cnt_q != CNT_MAX)) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Timeout fires on the edge that carries the TIMEOUT_SEC-th pulse.
  assign timeout = (cnt_q == CNT_LAST) && one_second;
`else
  logic unused_one_second;
  assign unused_one_second = one_second | (TIMEOUT_SEC == 0);
  assign timeout           = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= SHOW_TIME;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. Within each state, earlier tests have priority.
  always_comb begin
    state_d = state_q;
    case (state_q)
      SHOW_TIME: begin
        if (alarm_button)     state_d = SHOW_ALARM;
        else if (key_pressed) state_d = KEY_STORED;
      end
      KEY_STORED: state_d = KEY_WAITED;
      KEY_WAITED: begin
        if (!key_pressed) state_d = KEY_ENTRY;
        else if (timeout) state_d = SHOW_TIME;
      end
      KEY_ENTRY: begin
        if (alarm_button)     state_d = SET_ALARM_TIME;
        else if (time_button) state_d = SET_CURRENT_TIME;
        else if (key_pressed) state_d = KEY_STORED;
        else if (timeout)     state_d = SHOW_TIME;
      end
      SHOW_ALARM: begin
        if (!alarm_button) state_d = SHOW_TIME;
      end
      SET_ALARM_TIME:   state_d = SHOW_TIME;
      SET_CURRENT_TIME: state_d = SHOW_TIME;
      default:          state_d = SHOW_TIME;
    endcase
  end

  // Output decode
  always_comb begin
    load_new_a    = 1'b0;
    load_new_c    = 1'b0;
    show_a        = 1'b0;
    show_new_time = 1'b0;
    shift         = 1'b0;
    reset_count   = 1'b0;
    case (state_q)
      KEY_STORED:       shift         = 1'b1;
      KEY_WAITED:       show_new_time = 1'b1;
      KEY_ENTRY:        show_new_time = 1'b1;
      SHOW_ALARM:       show_a        = 1'b1;
      SET_ALARM_TIME:   load_new_a    = 1'b1;
      SET_CURRENT_TIME: begin
        load_new_c  = 1'b1;
        reset_count = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_aclk_controller.sv
module tb_aclk_controller;

  localparam int         TMO = 10;
  localparam logic [3:0] NK  = 4'hA;
`ifdef ACLK_CTRL_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       one_second;
  logic [3:0] key;
  logic       alarm_button;
  logic       time_button;
  logic       load_new_a, load_new_c, show_a, show_new_time, shift, reset_count;
  logic [5:0] dut_out;

  aclk_controller #(.TIMEOUT_SEC(TMO), .NOKEY(NK)) dut (
    .clk           (clk),
    .reset         (reset),
    .one_second    (one_second),
    .key           (key),
    .alarm_button  (alarm_button),
    .time_button   (time_button),
    .load_new_a    (load_new_a),
    .load_new_c    (load_new_c),
    .show_a        (show_a),
    .show_new_time (show_new_time),
    .shift         (shift),
    .reset_count   (reset_count)
  );

  always #5 clk = ~clk;

  assign dut_out = {load_new_a, load_new_c, show_a, show_new_time, shift, reset_count};

  // Reference model: what the user is doing, plus seconds of inactivity.
  typedef enum int {M_IDLE, M_SHIFT, M_HOLD, M_ENTRY, M_VIEW, M_LOAD_A, M_LOAD_C} mode_t;
  mode_t mode;
  int    secs;

  int n_chk, n_pass;
  int n_shift, n_lda, n_ldc, n_showa;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
  endtask

  // {load_new_a, load_new_c, show_a, show_new_time, shift, reset_count}
  function automatic logic [5:0] exp_out(mode_t m);
    case (m)
      M_SHIFT:         return 6'b000010;
      M_HOLD, M_ENTRY: return 6'b000100;
      M_VIEW:          return 6'b001000;
      M_LOAD_A:        return 6'b100000;
      M_LOAD_C:        return 6'b010001;
      default:         return 6'b000000;
    endcase
  endfunction

  task automatic model_step(input logic [3:0] k, input logic ab, input logic tb, input logic os);
    bit    pressed, to, waiting;
    mode_t nxt;
    pressed = (k != NK);
    waiting = (mode == M_HOLD) || (mode == M_ENTRY);
    to      = TMO_EN && os && (secs == TMO - 1);
    nxt     = mode;
    case (mode)
      M_IDLE:   if (ab) nxt = M_VIEW; else if (pressed) nxt = M_SHIFT;
      M_SHIFT:  nxt = M_HOLD;
      M_HOLD:   if (!pressed) nxt = M_ENTRY; else if (to) nxt = M_IDLE;
      M_ENTRY:  if (ab) nxt = M_LOAD_A; else if (tb) nxt = M_LOAD_C;
                else if (pressed) nxt = M_SHIFT; else if (to) nxt = M_IDLE;
      M_VIEW:   if (!ab) nxt = M_IDLE;
      default:  nxt = M_IDLE;
    endcase
    if (!waiting) secs = 0;
    else if (os && secs < TMO) secs = secs + 1;
    mode = nxt;
  endtask

  task automatic tick(input logic [3:0] k, input logic ab, input logic tb, input logic os,
                      input string tag);
    key = k; alarm_button = ab; time_button = tb; one_second = os;
    @(posedge clk);
    model_step(k, ab, tb, os);
    #1;
    check(tag, dut_out, exp_out(mode));
    n_shift += shift; n_lda += load_new_a; n_ldc += load_new_c; n_showa += show_a;
  endtask

  task automatic idle(input int n, input string tag);
    for (int i = 0; i < n; i++) tick(NK, 1'b0, 1'b0, 1'b0, tag);
  endtask

  task automatic press(input logic [3:0] k, input string tag);
    for (int i = 0; i < 3; i++) tick(k, 1'b0, 1'b0, 1'b0, tag);
    idle(2, tag);
  endtask

  task automatic pulses(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      tick(NK, 1'b0, 1'b0, 1'b1, tag);
      tick(NK, 1'b0, 1'b0, 1'b0, tag);
    end
  endtask

  // Asserted between edges; outputs must clear without waiting for a clock.
  task automatic async_reset(input string tag);
    #3 reset = 1'b1;
    #1;
    mode = M_IDLE; secs = 0;
    check(tag, dut_out, 6'b0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic clear_counts();
    n_shift = 0; n_lda = 0; n_ldc = 0; n_showa = 0;
  endtask

  initial begin
    n_chk = 0; n_pass = 0;
    clear_counts();
    mode = M_IDLE; secs = 0;
    reset = 1'b1; key = NK; alarm_button = 1'b0; time_button = 1'b0; one_second = 1'b0;
    #2;
    check("reset_outputs", dut_out, 6'b0);
    @(negedge clk); @(negedge clk);
    reset = 1'b0;

    // Reset in the middle of key entry
    press(4'd3, "t1_entry");
    check("t1_in_entry", show_new_time, 1'b1);
    async_reset("t1_async");
    idle(2, "t1_after");
    press(4'd6, "t1_restart");
    check("t1_restart_entry", show_new_time, 1'b1);
    async_reset("t1_async2");

    // Four digits then time button
    clear_counts();
    press(4'd1, "t2_k1");
    check("t2_show_new", show_new_time, 1'b1);
    press(4'd2, "t2_k2");
    press(4'd3, "t2_k3");
    press(4'd4, "t2_k4");
    tick(NK, 1'b0, 1'b1, 1'b0, "t2_timebtn");
    check("t2_loadc_pulse", {load_new_c, reset_count}, 2'b11);
    idle(3, "t2_tail");
    check("t2_shifts", n_shift, 4);
    check("t2_loadc_count", n_ldc, 1);
    check("t2_loada_count", n_lda, 0);

    // Key 0 then alarm button
    clear_counts();
    press(4'd0, "t3_k0");
    tick(NK, 1'b1, 1'b0, 1'b0, "t3_alarmbtn");
    idle(3, "t3_tail");
    check("t3_loada_count", n_lda, 1);
    check("t3_showa_count", n_showa, 0);

    // Alarm display while held
    clear_counts();
    for (int i = 0; i < 5; i++) tick(NK, 1'b1, 1'b0, 1'b0, "t4_hold");
    idle(3, "t4_release");
    check("t4_showa_cycles", n_showa, 5);
    check("t4_no_loads", n_lda + n_ldc, 0);

    // Inactivity timeout
    clear_counts();
    press(4'd5, "t5_k5");
    pulses(TMO, "t5_pulses");
    check("t5_after_tmo", show_new_time, TMO_EN ? 1'b0 : 1'b1);
    pulses(TMO, "t5_more");
    check("t5_after_20", show_new_time, TMO_EN ? 1'b0 : 1'b1);
    check("t5_no_loads", n_lda + n_ldc, 0);
    async_reset("t5_rst");
    press(4'd5, "t5b_k5");
    pulses(TMO - 1, "t5b_nine");
    press(4'd7, "t5b_k7");
    pulses(TMO - 1, "t5b_nine2");
    check("t5b_restarted", show_new_time, 1'b1);
    pulses(1, "t5b_last");
    check("t5b_final", show_new_time, TMO_EN ? 1'b0 : 1'b1);
    async_reset("t5b_rst");

    // Both buttons together in entry
    clear_counts();
    press(4'd2, "t6_k2");
    tick(NK, 1'b1, 1'b1, 1'b0, "t6_both");
    check("t6_loada", load_new_a, 1'b1);
    check("t6_loadc", load_new_c, 1'b0);
    idle(2, "t6_tail");
    check("t6_ldc_count", n_ldc, 0);

    // Invalid code acts as a digit
    press(4'hE, "t7_keyE");
    check("t7_keyE_entry", show_new_time, 1'b1);
    async_reset("t7_rst");

    // Randomized traffic
    begin
      logic [3:0] k;
      int         hold;
      hold = 0; k = NK;
      for (int i = 0; i < 1500; i++) begin
        if (hold == 0) begin
          k    = ($urandom % 3 == 0) ? 4'($urandom % 16) : NK;
          hold = 1 + $urandom % 4;
        end
        hold--;
        tick(k, ($urandom % 10) == 0, ($urandom % 8) == 0, ($urandom % 3) == 0, "rand");
        if (i % 250 == 249) async_reset("rand_rst");
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
